hardware_binarize_stream: RTL

Streaming, parametrised successor to the single-node SKI binarizer. It accepts one SKI graph node per handshake and emits fixed-width binary words on a registered valid/ready stream. In the optional pack mode, runs of nullary combinators (S/K/I) are packed into one word. It sits between the reducer's node store and the serial dump/host link.

---
 rtl/hardware_ski_pkg.sv | 36 +++
 rtl/hardware_binarize_node.sv | 40 ++++
 rtl/hardware_binarize_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hardware_ski_pkg.sv
// Shared definitions for the SKI graph binarizers.
// Holds input node tags, output word tags, the 2-bit token codes used in pack
// words, and width helpers that derive node/word widths from the pointer width.
package hardware_ski_pkg;

  // Input node tags (top 3 bits of a node)
  localparam logic [2:0] TAG_S   = 3'd0;
  localparam logic [2:0] TAG_K   = 3'd1;
  localparam logic [2:0] TAG_I   = 3'd2;
  localparam logic [2:0] TAG_APP = 3'd3;
  localparam logic [2:0] TAG_LIT = 3'd4;

  // Output word tags (top 4 bits of a word)
  localparam logic [3:0] OTAG_S    = 4'h0;
  localparam logic [3:0] OTAG_K    = 4'h1;
  localparam logic [3:0] OTAG_I    = 4'h2;
  localparam logic [3:0] OTAG_APP  = 4'h3;
  localparam logic [3:0] OTAG_LIT  = 4'h4;
  localparam logic [3:0] OTAG_PACK = 4'h5;

  // Token codes inside a pack word; they equal the low two bits of the
  // nullary input tags and the low two bits of the nullary output tags.
  typedef logic [1:0] tok_t;
  localparam tok_t TOK_S = 2'd0;
  localparam tok_t TOK_K = 2'd1;
  localparam tok_t TOK_I = 2'd2;

  function automatic int in_width(input int ptr_w);
    return 3 + 2 * ptr_w;
  endfunction

  function automatic int out_width(input int ptr_w);
    return 4 + 2 * ptr_w;
  endfunction

endpackage

// File: rtl/hardware_binarize_node.sv
// Combinational single-node encoder.
// Ports:
//   node    - input node, tag in the top 3 bits, payload below
//   word    - encoded output word (S/K/I, App or Lit form)
//   illegal - high when the tag is not one of S/K/I/App/Lit
module hardware_binarize_node
  import hardware_ski_pkg::*;
#(
  parameter int PTR_W = 30,
  parameter int LIT_W = 32
) (
  input  logic [2*PTR_W+2:0] node,
  output logic [2*PTR_W+3:0] word,
  output logic               illegal
);

  localparam int IN_W  = in_width(PTR_W);
  localparam int OUT_W = out_width(PTR_W);

  logic [2:0] tag;
  assign tag = node[IN_W-1 -: 3];

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (tag)
      TAG_S:   word[OUT_W-1 -: 4] = OTAG_S;
      TAG_K:   word[OUT_W-1 -: 4] = OTAG_K;
      TAG_I:   word[OUT_W-1 -: 4] = OTAG_I;
      // a and b keep their positions, just shifted under the wider tag
      TAG_APP: word = {OTAG_APP, node[2*PTR_W-1:0]};
      TAG_LIT: begin
        word[OUT_W-1 -: 4] = OTAG_LIT;
        word[LIT_W-1:0]    = node[2*PTR_W-1 -: LIT_W];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/hardware_binarize_stream.sv
// Streaming SKI node binarizer with optional packing of S/K/I runs.
// Ports:
//   system1000 / system1000_rst - clock, synchronous active-high reset
//   pack_en                      - pack mode, sampled while accumulator empty
//   in_node/in_valid/in_ready/in_last     - input node stream
//   out_word/out_valid/out_ready/out_last - registered output word stream
//   err                          - sticky illegal-tag flag
module hardware_binarize_stream
  import hardware_ski_pkg::*;
#(
  parameter int PTR_W    = 30,
  parameter int LIT_W    = 32,
  parameter int MAX_PACK = 27
) (
  input  logic               system1000,
  input  logic               system1000_rst,
  input  logic               pack_en,
  input  logic [2*PTR_W+2:0] in_node,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  output logic [2*PTR_W+3:0] out_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               err
);

  localparam int IN_W  = in_width(PTR_W);
  localparam int OUT_W = out_width(PTR_W);
  localparam int TOK_W = 2 * MAX_PACK;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [5:0]       cnt_reg, cnt_next;
  logic [TOK_W-1:0] tok_reg, tok_next;
  logic [OUT_W-1:0] hold_word_reg, hold_word_next;
  logic             hold_last_reg, hold_last_next;
  logic [OUT_W-1:0] out_word_reg, out_word_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_last_reg, out_last_next;
  logic             err_reg, err_next;

  logic [OUT_W-1:0] enc_word;
  logic             enc_illegal;
  logic [2:0]       tag;
  logic             nullary;
  logic             out_free;
  logic             accept;
  logic [5:0]       cnt_inc;
  logic [TOK_W-1:0] tok_app;

  hardware_binarize_node #(
    .PTR_W (PTR_W),
    .LIT_W (LIT_W)
  ) u_node (
    .node    (in_node),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Word emitted when the accumulator flushes: a lone token goes out as its
  // plain S/K/I word (output tag equals the token code), otherwise a pack word.
  function automatic logic [OUT_W-1:0] flush_word(input logic [5:0] c,
                                                  input logic [TOK_W-1:0] t);
    logic [OUT_W-1:0] w;
    w = '0;
    if (c == 6'd1) begin
      w[OUT_W-1 -: 4] = {2'b00, t[1:0]};
    end else begin
      w[OUT_W-1 -: 4] = OTAG_PACK;
      w[OUT_W-5 -: 6] = c;
      w[TOK_W-1:0]    = t;
    end
    return w;
  endfunction

  assign tag      = in_node[IN_W-1 -: 3];
  assign nullary  = (tag < TAG_APP);
  assign out_free = !out_valid_reg || out_ready;
  assign in_ready = (state_reg != ST_HOLD) && out_free;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_reg + 6'd1;

  // Accumulator with the incoming token appended at slot cnt_reg
  always_comb begin
    tok_app = tok_reg;
    tok_app[{cnt_reg, 1'b0} +: 2] = tag[1:0];
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    tok_next       = tok_reg;
    hold_word_next = hold_word_reg;
    hold_last_next = hold_last_reg;
    out_word_next  = out_word_reg;
    out_last_next  = out_last_reg;
    out_valid_next = out_valid_reg && !out_ready;
    err_next       = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (enc_illegal) begin
            err_next = 1'b1;
          end else if (nullary && pack_en && !in_last) begin
            state_next   = ST_ACC;
            cnt_next     = 6'd1;
            tok_next     = '0;
            tok_next[1:0] = tag[1:0];
          end else begin
            out_word_next  = enc_word;
            out_last_next  = in_last;
            out_valid_next = 1'b1;
          end
        end
      end

      ST_ACC: begin
        if (accept) begin
          if (enc_illegal) begin
            err_next       = 1'b1;
            out_word_next  = flush_word(cnt_reg, tok_reg);
            out_last_next  = in_last;
            out_valid_next = 1'b1;
            state_next     = ST_IDLE;
            cnt_next       = 6'd0;
            tok_next       = '0;
          end else if (nullary) begin
            if (cnt_inc == 6'(MAX_PACK) || in_last) begin
              out_word_next  = flush_word(cnt_inc, tok_app);
              out_last_next  = in_last;
              out_valid_next = 1'b1;
              state_next     = ST_IDLE;
              cnt_next       = 6'd0;
              tok_next       = '0;
            end else begin
              cnt_next = cnt_inc;
              tok_next = tok_app;
            end
          end else begin
            // Pack word goes first; the App/Lit word waits one cycle behind it
            out_word_next  = flush_word(cnt_reg, tok_reg);
            out_last_next  = 1'b0;
            out_valid_next = 1'b1;
            hold_word_next = enc_word;
            hold_last_next = in_last;
            state_next     = ST_HOLD;
            cnt_next       = 6'd0;
            tok_next       = '0;
          end
        end
      end

      ST_HOLD: begin
        if (out_free) begin
          out_word_next  = hold_word_reg;
          out_last_next  = hold_last_reg;
          out_valid_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 6'd0;
      tok_reg       <= '0;
      hold_word_reg <= '0;
      hold_last_reg <= 1'b0;
      out_word_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      tok_reg       <= tok_next;
      hold_word_reg <= hold_word_next;
      hold_last_reg <= hold_last_next;
      out_word_reg  <= out_word_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      err_reg       <= err_next;
    end
  end

  assign out_word  = out_word_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign err       = err_reg;

endmodule
